// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-item vending controller.
//   vm_state_e : controller state (IDLE / CREDIT / CHANGE)
//   C_*        : coin/change codes, value k = k units of Rs5
//   price_of   : unpacks one 8-bit price from a packed price vector
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    CHANGE = 2'd2
  } vm_state_e;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_5    = 3'd1;
  localparam logic [2:0] C_10   = 3'd2;
  localparam logic [2:0] C_15   = 3'd3;
  localparam logic [2:0] C_20   = 3'd4;

  // Price vectors are zero-extended to 256b so one function serves any item count.
  function automatic logic [7:0] price_of(input logic [255:0] prices, input int unsigned idx);
    return prices[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Greedy change selector: offers the largest legal coin not exceeding the credit.
//   credit   in  CREDIT_W  remaining credit in units
//   chg_coin out COIN_W    min(credit, MAX_COIN)
module vm_change_gen #(
  parameter int CREDIT_W = 8,
  parameter int COIN_W   = 3,
  parameter int MAX_COIN = 4
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [COIN_W-1:0]   chg_coin
);

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_COIN);

  always_comb begin
    chg_coin = (credit > MAX_C) ? COIN_W'(MAX_COIN) : credit[COIN_W-1:0];
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: accumulates coin credit, vends an item when
// credit covers its price, tracks per-item stock, returns change coin by coin.
//   clk/rst                 clock, async active-low reset
//   coin_valid/coin/ready   coin acceptor handshake; coin_reject pulses on bad coin
//   sel_valid/sel_item      keypad selection; vend/vend_item or sel_err pulse
//   cancel                  refund all credit through the change path
//   chg_valid/coin/ready    hopper handshake, one coin per accepted transfer
//   credit, sold_out        status
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                     N_ITEMS    = 4,
  parameter int                     COIN_W     = 3,
  parameter int                     MAX_COIN   = 4,
  parameter int                     CREDIT_W   = 8,
  parameter int                     MAX_CREDIT = 40,
  parameter logic [N_ITEMS*8-1:0]   PRICES     = {8'd4, 8'd3, 8'd2, 8'd1},
  parameter int                     STOCK_W    = 4,
  parameter int                     STOCK_INIT = 10,
  localparam int                    SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin,
  output logic                coin_ready,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_item,
  output logic                sel_err,
  output logic                chg_valid,
  output logic [COIN_W-1:0]   chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  sold_out
);

  localparam logic [SEL_W:0] N_ITEMS_W = (SEL_W+1)'(N_ITEMS);

  vm_state_e                        state_q, state_d;
  logic [CREDIT_W-1:0]              credit_q, credit_d;
  logic [N_ITEMS-1:0][STOCK_W-1:0]  stock_q, stock_d;
  logic                             vend_q, vend_d;
  logic                             rej_q, rej_d;
  logic                             err_q, err_d;
  logic [SEL_W-1:0]                 vend_item_q, vend_item_d;

  logic [N_ITEMS-1:0][7:0]          price_arr;
  logic [COIN_W-1:0]                chg_coin_w;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    assign price_arr[i] = price_of(256'(PRICES), i);
    assign sold_out[i]  = (stock_q[i] == '0);
  end

  vm_change_gen #(.CREDIT_W(CREDIT_W), .COIN_W(COIN_W), .MAX_COIN(MAX_COIN)) u_chg (
    .credit   (credit_q),
    .chg_coin (chg_coin_w)
  );

  // Selection decode; out-of-range indices are masked before any array lookup matters.
  logic                sel_idx_ok, sel_good;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_bad;

  always_comb begin
    sel_idx_ok = ({1'b0, sel_item} < N_ITEMS_W);
    sel_price  = sel_idx_ok ? CREDIT_W'(price_arr[sel_item]) : '0;
    sel_stock  = sel_idx_ok ? stock_q[sel_item] : '0;
    sel_good   = sel_idx_ok && (sel_stock != '0) && (credit_q >= sel_price);
    coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin);
    coin_bad   = (coin == COIN_W'(C_NONE)) || (coin > COIN_W'(MAX_COIN)) ||
                 (coin_sum > (CREDIT_W+1)'(MAX_CREDIT));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      stock_q     <= {N_ITEMS{STOCK_W'(STOCK_INIT)}};
      vend_q      <= 1'b0;
      rej_q       <= 1'b0;
      err_q       <= 1'b0;
      vend_item_q <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_q     <= stock_d;
      vend_q      <= vend_d;
      rej_q       <= rej_d;
      err_q       <= err_d;
      vend_item_q <= vend_item_d;
    end
  end

  // Next state / datapath. Outside CHANGE: cancel > selection > coin.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    stock_d     = stock_q;
    vend_d      = 1'b0;
    rej_d       = 1'b0;
    err_d       = 1'b0;
    vend_item_d = vend_item_q;
    case (state_q)
      CHANGE: begin
        if (chg_ready) begin
          credit_d = credit_q - CREDIT_W'(chg_coin_w);
          if (credit_d == '0) state_d = IDLE;
        end
      end
      default: begin
        if (cancel) begin
          if (credit_q != '0) state_d = CHANGE;
        end else if (sel_valid) begin
          if (!sel_good) begin
            err_d = 1'b1;
          end else begin
            vend_d            = 1'b1;
            vend_item_d       = sel_item;
            credit_d          = credit_q - sel_price;
            stock_d[sel_item] = stock_q[sel_item] - 1'b1;
            state_d           = (credit_d != '0) ? CHANGE : IDLE;
          end
        end else if (coin_valid) begin
          if (coin_bad) begin
            rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    coin_ready = (state_q != CHANGE) && !cancel && !sel_valid;
    chg_valid  = (state_q == CHANGE);
    chg_coin   = chg_valid ? chg_coin_w : '0;
  end

  assign coin_reject = rej_q;
  assign sel_err     = err_q;
  assign vend        = vend_q;
  assign vend_item   = vend_item_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed + random bench for vending_machine_multi against a money/stock model.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, coin_ready, coin_reject;
  logic [2:0] coin;
  logic       sel_valid, cancel, vend, sel_err, chg_valid, chg_ready;
  logic [1:0] sel_item, vend_item;
  logic [2:0] chg_coin;
  logic [7:0] credit;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin(coin), .coin_ready(coin_ready), .coin_reject(coin_reject),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .vend(vend), .vend_item(vend_item), .sel_err(sel_err),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
    .credit(credit), .sold_out(sold_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: money in units, refunding flag, stock per item.
  int price_tbl [4] = '{1, 2, 3, 4};
  int m_credit;
  bit m_refund;
  int m_stock [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_credit = 0;
    m_refund = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 10;
  endtask

  function automatic logic [31:0] sold_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) m[i] = (m_stock[i] == 0);
    return m;
  endfunction

  function automatic int min_chg();
    return (m_credit > 4) ? 4 : m_credit;
  endfunction

  // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic step(input bit cv, input int c, input bit sv, input int si, input bit can, input bit cr);
    bit e_vend, e_rej, e_err;
    int e_item;
    e_vend = 0; e_rej = 0; e_err = 0; e_item = 0;
    @(negedge clk);
    coin_valid = cv; coin = c[2:0]; sel_valid = sv; sel_item = si[1:0];
    cancel = can; chg_ready = cr;
    #1;
    chk("coin_ready", coin_ready, !m_refund && !can && !sv);
    chk("chg_valid_pre", chg_valid, m_refund);
    if (m_refund) chk("chg_coin", chg_coin, min_chg());
    if (m_refund) begin
      if (cr) begin
        m_credit -= min_chg();
        if (m_credit == 0) m_refund = 0;
      end
    end else if (can) begin
      if (m_credit > 0) m_refund = 1;
    end else if (sv) begin
      if (si >= 4 || m_stock[si] == 0 || m_credit < price_tbl[si]) e_err = 1;
      else begin
        e_vend = 1; e_item = si;
        m_credit -= price_tbl[si];
        m_stock[si]--;
        m_refund = (m_credit > 0);
      end
    end else if (cv) begin
      if (c == 0 || c > 4 || m_credit + c > 40) e_rej = 1;
      else m_credit += c;
    end
    @(posedge clk);
    #1;
    chk("vend", vend, e_vend);
    if (e_vend) chk("vend_item", vend_item, e_item);
    chk("coin_reject", coin_reject, e_rej);
    chk("sel_err", sel_err, e_err);
    chk("credit", credit, m_credit);
    chk("chg_valid", chg_valid, m_refund);
    chk("sold_out", sold_out, sold_mask());
  endtask

  // Take change, holding chg_ready low for 'stall' cycles before each coin.
  task automatic drain(input int stall);
    for (int k = 0; k < 60 && m_refund; k++) begin
      repeat (stall) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    chk("drain_done", chg_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; coin_valid = 0; coin = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; chg_ready = 0;
    m_reset();
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_chg_valid", chg_valid, 0);
    chk("rst_vend", vend, 0);
    chk("rst_vend_item", vend_item, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_sold_out", sold_out, 0);
    @(negedge clk) rst = 1'b1;

    // Two Rs10 coins then item 1, change returned.
    step(1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    drain(0);

    // Fill to ceiling, overflow coin rejected, cancel with stalled hopper.
    repeat (10) step(1, 4, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    drain(3);

    // Sell out item 0, then the 11th selection errors and keeps credit.
    repeat (10) begin
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
    end
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    drain(0);

    // Insufficient credit; coin and selection in the same cycle.
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(1, 3, 1, 3, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    drain(1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 2, 0, 0, 1, 0);

    // Random traffic.
    repeat (300) begin
      int r;
      r = $urandom_range(0, 9);
      step($urandom_range(0, 1), $urandom_range(0, 7), (r >= 1 && r <= 3),
           $urandom_range(0, 3), (r == 0), $urandom_range(0, 1));
    end
    drain(0);
    step(0, 0, 0, 0, 1, 0);
    drain(0);

    // Async reset while returning change from credit 7.
    step(1, 4, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pre_rst_credit", credit, 7);
    chk("pre_rst_chg_valid", chg_valid, 1);
    @(negedge clk);
    chg_ready = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_credit", credit, 0);
    chk("async_rst_chg_valid", chg_valid, 0);
    chk("async_rst_sold_out", sold_out, 0);
    m_reset();
    @(negedge clk) rst = 1'b1;

    // Stock restored to 10: item 0 sells out exactly on the 10th purchase.
    repeat (10) begin
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
    end
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
